// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file types for the writeback path
package rf_pkg;
  localparam int RF_ADDR_W = 3;
  localparam int RF_DATA_W = 16;
  localparam int RF_DEPTH  = 8;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} grant_t;
endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// rtl/rf_wb_arbiter_rr_arb2.sv - 2-way round-robin arbiter owning the last_grant register
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  grant_t last_grant;

  // req[0] is A, req[1] is B; a tie goes to whoever did not win last
  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      if (req == 2'b11) gnt = (last_grant == GNT_B) ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)       last_grant <= GNT_B;
    else if (gnt[0]) last_grant <= GNT_A;
    else if (gnt[1]) last_grant <= GNT_B;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - shares the RegFile write port between ALU and load writeback
// Optional forwarding-hit outputs are built when RF_WB_BYPASS_EN is defined.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int ADDR_W      = RF_ADDR_W,
  parameter int DATA_W      = RF_DATA_W,
  parameter int ZERO_REG_EN = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_req,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_data,
  output logic                a_ack,
  input  logic                b_req,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_data,
  output logic                b_ack,
  input  logic                sb_set,
  input  logic [ADDR_W-1:0]   sb_set_addr,
  output logic                rf_write,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [RF_DEPTH-1:0] pending
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]   chk_addr1,
  input  logic [ADDR_W-1:0]   chk_addr2,
  output logic                fwd_hit1,
  output logic                fwd_hit2
`endif
);

  logic [1:0]          gnt;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic                win_drop;
  logic                wr_next;
  logic [RF_DEPTH-1:0] set_mask;
  logic [RF_DEPTH-1:0] clr_mask;

  rr_arb2 u_arb (
    .clock (clock),
    .reset (reset),
    .req   ({b_req, a_req}),
    .gnt   (gnt)
  );

  assign a_ack = gnt[0];
  assign b_ack = gnt[1];

  always_comb begin
    win_addr = gnt[1] ? b_addr : a_addr;
    win_data = gnt[1] ? b_data : a_data;
    // writes to the hardwired zero register still consume a grant
    win_drop = (ZERO_REG_EN != 0) && (win_addr == '0);
    wr_next  = (|gnt) && !win_drop;
    set_mask = '0;
    clr_mask = '0;
    if (sb_set && !((ZERO_REG_EN != 0) && (sb_set_addr == '0))) set_mask[sb_set_addr] = 1'b1;
    if (rf_write) clr_mask[rf_waddr] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rf_write <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      pending  <= '0;
    end else begin
      rf_write <= wr_next;
      if (wr_next) begin
        rf_waddr <= win_addr;
        rf_wdata <= win_data;
      end
      // a newer producer issuing on the same edge as the write keeps the bit set
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

`ifdef RF_WB_BYPASS_EN
  assign fwd_hit1 = rf_write && (rf_waddr == chk_addr1) && (rf_waddr != '0);
  assign fwd_hit2 = rf_write && (rf_waddr == chk_addr2) && (rf_waddr != '0);
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_req, b_req, sb_set;
  logic [2:0]  a_addr, b_addr, sb_set_addr;
  logic [15:0] a_data, b_data;
  logic        a_ack, b_ack, rf_write;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [7:0]  pending;
`ifdef RF_WB_BYPASS_EN
  logic [2:0]  chk_addr1 = 3'd0, chk_addr2 = 3'd0;
  logic        fwd_hit1, fwd_hit2;
`endif

  rf_wb_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .a_req       (a_req),
    .a_addr      (a_addr),
    .a_data      (a_data),
    .a_ack       (a_ack),
    .b_req       (b_req),
    .b_addr      (b_addr),
    .b_data      (b_data),
    .b_ack       (b_ack),
    .sb_set      (sb_set),
    .sb_set_addr (sb_set_addr),
    .rf_write    (rf_write),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .pending     (pending)
`ifdef RF_WB_BYPASS_EN
    ,
    .chk_addr1   (chk_addr1),
    .chk_addr2   (chk_addr2),
    .fwd_hit1    (fwd_hit1),
    .fwd_hit2    (fwd_hit2)
`endif
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int          c;
    logic [2:0]  addr;
    logic [15:0] data;
  } wr_t;
  wr_t exp_q[$];

  // reference model state
  logic       tie_a  = 1'b1;
  logic [7:0] m_pend = 8'h00;
  logic       m_wr_v = 1'b0;
  logic [2:0] m_wr_a = 3'd0;

  logic [15:0] rf_mem [8];

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= 16'h0;
    end else if (rf_write) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every visible write must match the oldest expected write, in its cycle
  always @(negedge clock) begin
    wr_t w;
    if (rf_write) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {31'd0, rf_write}, 32'd0);
      end else begin
        w = exp_q.pop_front();
        chk("wr_cycle", cyc, w.c);
        chk("wr_addr", {29'd0, rf_waddr}, {29'd0, w.addr});
        chk("wr_data", {16'd0, rf_wdata}, {16'd0, w.data});
      end
    end else if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
      w = exp_q.pop_front();
      chk("missed_write", {31'd0, rf_write}, 32'd1);
    end
  end

  task automatic tick();
    logic        ea, eb, ws, rs;
    logic [2:0]  wa, sa;
    logic [15:0] wd;
    int          gc;
    @(negedge clock);
    rs = reset;
    ea = 1'b0;
    eb = 1'b0;
    if (!rs) begin
      if (a_req && b_req) begin
        ea = tie_a;
        eb = !tie_a;
      end else begin
        ea = a_req;
        eb = b_req;
      end
    end
    chk("a_ack", {31'd0, a_ack}, {31'd0, ea});
    chk("b_ack", {31'd0, b_ack}, {31'd0, eb});
    chk("pending", {24'd0, pending}, {24'd0, m_pend});
    wa = eb ? b_addr : a_addr;
    wd = eb ? b_data : a_data;
    ws = sb_set && (sb_set_addr != 3'd0);
    sa = sb_set_addr;
    gc = cyc;
    @(posedge clock);
    if (rs) begin
      m_pend = 8'h00;
      m_wr_v = 1'b0;
      tie_a  = 1'b1;
    end else begin
      if (m_wr_v) m_pend[m_wr_a] = 1'b0;
      if (ws) m_pend[sa] = 1'b1;
      m_wr_v = 1'b0;
      if (ea || eb) begin
        tie_a = eb;
        if (wa != 3'd0) begin
          m_wr_v = 1'b1;
          m_wr_a = wa;
          exp_q.push_back('{c: gc + 1, addr: wa, data: wd});
        end
      end
    end
    #1;
    if (ea) a_req = 1'b0;
    if (eb) b_req = 1'b0;
    sb_set = 1'b0;
  endtask

  task automatic set_a(input logic [2:0] ad, input logic [15:0] d);
    a_req = 1'b1; a_addr = ad; a_data = d;
  endtask

  task automatic set_b(input logic [2:0] ad, input logic [15:0] d);
    b_req = 1'b1; b_addr = ad; b_data = d;
  endtask

  task automatic mark(input logic [2:0] ad);
    sb_set = 1'b1; sb_set_addr = ad;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    a_req = 1'b0; a_addr = 3'd0; a_data = 16'h0;
    b_req = 1'b0; b_addr = 3'd0; b_data = 16'h0;
    sb_set = 1'b0; sb_set_addr = 3'd0;
    tick();
    tick();
    chk("rst_rf_write", {31'd0, rf_write}, 32'd0);
    chk("rst_rf_waddr", {29'd0, rf_waddr}, 32'd0);
    chk("rst_rf_wdata", {16'd0, rf_wdata}, 32'd0);
    chk("rst_pending", {24'd0, pending}, 32'd0);
    reset = 1'b0;

    // single write
    set_a(3'd1, 16'd9);
    tick();
    tick();
    tick();
    chk("reg1_read", {16'd0, rf_mem[1]}, 32'd9);

    // contention from reset: A then B
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_a(3'd6, 16'd7);
    set_b(3'd3, 16'd5);
    repeat (4) tick();

    // fairness: both re-request every cycle
    for (int i = 0; i < 6; i++) begin
      set_a(3'd2, 16'h100 + 16'(i));
      set_b(3'd4, 16'h200 + 16'(i));
      tick();
    end
    a_req = 1'b0;
    b_req = 1'b0;
    tick();

    // scoreboard set, then B writes r6 three cycles later
    mark(3'd6);
    tick();
    chk("sb_pending_set", {24'd0, pending}, 32'h40);
    tick();
    tick();
    set_b(3'd6, 16'h0066);
    tick();
    tick();
    tick();
    chk("sb_pending_clr", {24'd0, pending}, 32'h00);

    // set on the same edge as the write: set wins
    mark(3'd6);
    tick();
    set_b(3'd6, 16'h0606);
    tick();
    mark(3'd6);
    tick();
    chk("sb_set_wins", {24'd0, pending}, 32'h40);
    tick();

    // zero register
    set_a(3'd0, 16'hFFFF);
    tick();
    tick();
    chk("zero_no_write", {31'd0, rf_write}, 32'd0);
    mark(3'd0);
    tick();
    tick();
    chk("zero_pending", {31'd0, pending[0]}, 32'd0);
    chk("reg0_read", {16'd0, rf_mem[0]}, 32'd0);

    // reset in the cycle after a grant
    set_a(3'd2, 16'h0022);
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_rf_write", {31'd0, rf_write}, 32'd0);
    chk("midrst_pending", {24'd0, pending}, 32'd0);
    reset = 1'b0;
    set_a(3'd5, 16'h0055);
    set_b(3'd7, 16'h0077);
    tick();
    tick();
    tick();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (!a_req && $urandom_range(0, 2) != 0) set_a(3'($urandom), 16'($urandom));
      if (!b_req && $urandom_range(0, 2) != 0) set_b(3'($urandom), 16'($urandom));
      if ($urandom_range(0, 3) == 0) mark(3'($urandom));
      tick();
    end

    reset = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (4) tick();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single write port of the 8 x 16 register file (RegFile) between two writeback requesters: A (ALU writeback) and B (memory/load writeback).
- Arbitration is round-robin with a req/ack handshake.
- Outputs are registered and drive RegFile's rf_write, rf_waddr and rf_wdata directly.
- Holds an 8-bit pending-write scoreboard that the issue logic uses to detect read-after-write hazards.

Parameters:
- ADDR_W, 3, register address width (8 registers)
- DATA_W, 16, register data width
- ZERO_REG_EN, 1, when 1, register 0 is hardwired zero: writes to it are acked but dropped

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- a_req  in  1  requester A has a write pending
- a_addr  in  ADDR_W  requester A destination register
- a_data  in  DATA_W  requester A write data
- a_ack  out  1  A accepted this cycle (combinational)
- b_req  in  1  requester B has a write pending
- b_addr  in  ADDR_W  requester B destination register
- b_data  in  DATA_W  requester B write data
- b_ack  out  1  B accepted this cycle (combinational)
- sb_set  in  1  issue logic marks a destination register as pending
- sb_set_addr  in  ADDR_W  register to mark pending
- rf_write  out  1  RegFile write enable (registered)
- rf_waddr  out  ADDR_W  RegFile write address (registered)
- rf_wdata  out  DATA_W  RegFile write data (registered)
- pending  out  8  scoreboard; bit i = register i awaiting writeback (registered)

Behaviour:
- Reset (synchronous): rf_write=0, rf_waddr=0, rf_wdata=0, pending=0, last_grant=B.
  - Because last_grant=B, A wins the first tie.
  - a_ack and b_ack are 0 while reset is high.
- Handshake:
  - A requester holds req, addr and data stable until it sees ack high at a rising edge.
  - The requester may drop req or present new data in the cycle after ack.
  - Acks are combinational from the current req and last_grant, and never both high.
- Arbitration:
  - Only A requests: grant A. Only B requests: grant B.
  - Both request: grant the one that is not last_grant.
  - last_grant updates only on a grant, so an idle cycle leaves the priority unchanged.
- Latency:
  - A grant in cycle N registers rf_write=1 with the granted addr/data at the end of N.
  - RegFile captures the write at the following edge (end of N+1).
  - rf_write returns to 0 in the first cycle with no grant.
- Throughput:
  - One write per cycle.
  - Back-to-back grants produce rf_write high in consecutive cycles.
- Zero register (ZERO_REG_EN=1):
  - A granted request with addr=0 is acked, but rf_write stays 0 for that slot.
  - It still counts as a grant for round-robin.
  - sb_set to address 0 is ignored; pending[0] is always 0.
- Scoreboard:
  - pending[i] is cleared at the edge where RegFile performs the write to i (rf_write=1 and rf_waddr=i).
  - pending[i] is set at an edge with sb_set=1 and sb_set_addr=i.
  - Set and clear on the same register at the same edge: set wins, because a newer producer has issued.
  - Set or clear on an already set/clear bit is harmless.
- Reset mid-operation: any registered write still in flight is discarded (rf_write=0 in the cycle after reset). Both requesters must re-request.
- Both acks are 0 when neither requester is active.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- When defined:
  - Adds inputs chk_addr1 and chk_addr2 (ADDR_W each) and outputs fwd_hit1 and fwd_hit2.
  - fwd_hitK = rf_write and (rf_waddr == chk_addrK) and (rf_waddr != 0), computed combinationally.
  - Lets read-side logic forward rf_wdata before the register file updates.
- When undefined: these ports do not exist and nothing else changes.

Decomposition:
- Package rf_pkg holds:
  - RF_ADDR_W=3, RF_DATA_W=16, RF_DEPTH=8
  - typedefs rf_addr_t and rf_data_t
  - enum grant_t {GNT_A, GNT_B}
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter.
  - Inputs: clock, reset, req[1:0].
  - Outputs: gnt[1:0] (one-hot or zero).
  - Owns the last_grant register.

Test Plan:
- Single write: a_req=1, a_addr=1, a_data=9 for one cycle.
  - Expect a_ack=1 that cycle, then rf_write=1, rf_waddr=1, rf_wdata=9 next cycle.
  - A RegFile read of register 1 returns 9 afterwards.
- Contention: a_req and b_req both held (A: r6=7, B: r3=5) from reset.
  - Expect grant order A, B with acks in consecutive cycles.
  - Expect rf_waddr sequence 6 then 3, with rf_write high two consecutive cycles.
- Fairness: both requesters re-request every cycle for 6 cycles.
  - Expect strictly alternating acks A,B,A,B,A,B with no double grant.
- Scoreboard: sb_set with addr=6, then B writes r6 three cycles later.
  - Expect pending=8'b0100_0000 until the RegFile write edge, then 0.
  - Repeat with sb_set=6 issued at the same edge as the write: pending[6] stays 1.
- Zero register: a_req=1, a_addr=0, a_data=16'hFFFF.
  - Expect a_ack=1, rf_write stays 0, register 0 still reads 0.
  - sb_set with addr=0 leaves pending=0.
- Reset mid-operation: assert reset in the cycle after a grant.
  - Expect rf_write=0, pending=0 and no RegFile update.
  - The next tie after reset is granted to A.
